// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result path: word/tag widths,
// the queued result entry, and the canonical compare-op result words.
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_TAG_W  = 5;

  localparam logic [ALU_DATA_W-1:0] ALU_TRUE  = '1;
  localparam logic [ALU_DATA_W-1:0] ALU_FALSE = '0;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] result;
    logic                  flag;
    logic [ALU_TAG_W-1:0]  tag;
  } alu_entry_t;

  // A zero flag is consistent only when it matches "result is all zeros".
  function automatic logic flag_mismatch(input logic [ALU_DATA_W-1:0] result,
                                         input logic                  flag);
    return flag != (result == ALU_FALSE);
  endfunction

endpackage

// File: rtl/alu_fifo_mem.sv
// DEPTH-entry register array holding queued ALU results: one synchronous
// write port and an asynchronous read of the head slot.
module alu_fifo_mem
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  alu_entry_t        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output alu_entry_t        rdata
);

  alu_entry_t mem [DEPTH];

  // NOTE: the array is deliberately left out of reset; validity is tracked
  // by the pointers, so stale slots are never observed and no reset fan-out
  // is spent on storage.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// Result FIFO between the ALU compare/arithmetic units and writeback, with a
// saturating zero-flag counter and a sticky flag/result consistency error.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = ALU_DATA_W,
  parameter int TAG_W  = ALU_TAG_W,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_result,
  input  logic                     in_flag,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_result,
  output logic                     out_flag,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         zero_cnt,
  output logic                     flag_err
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam logic [PTR_W-1:0] FULL_LEVEL = PTR_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr, rd_ptr, level_q;
  logic [PTR_W-1:0] wr_ptr_d, rd_ptr_d, level_d;
  logic             push, pop, accept;
  alu_entry_t       wr_entry, head;

  // Ready and valid come straight from registered occupancy; out_ready never
  // reaches in_ready, so a full FIFO refuses a push even while draining.
  assign in_ready  = (level_q != FULL_LEVEL);
  assign out_valid = (level_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign accept    = push & ~flush;

  always_comb begin
    // NOTE: every output of this block gets a default before any branch so
    // no path leaves a value unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + PTR_W'(1);
        2'b01:   level_d = level_q - PTR_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr_d;
      rd_ptr  <= rd_ptr_d;
      level_q <= level_d;
    end
  end

  // Statistics survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_cnt <= '0;
      flag_err <= 1'b0;
    end else if (accept) begin
      if (in_flag && (zero_cnt != '1)) zero_cnt <= zero_cnt + CNT_W'(1);
      if (flag_mismatch(in_result, in_flag)) flag_err <= 1'b1;
    end
  end

  always_comb begin
    wr_entry        = '0;
    wr_entry.result = in_result;
    wr_entry.flag   = in_flag;
    wr_entry.tag    = in_tag;
  end

  alu_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (head)
  );

  assign out_result = out_valid ? head.result : '0;
  assign out_flag   = out_valid ? head.flag   : 1'b0;
  assign out_tag    = out_valid ? head.tag    : '0;
  assign level      = level_q;

endmodule
